// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand/stage encodings, scoreboard entry layout
// and default multiply/divide latencies.
package pipe_pkg;

  localparam int unsigned RA_W_DEF    = 5;
  localparam int unsigned T_W_DEF     = 2;
  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  localparam int unsigned STG_E = 1;
  localparam int unsigned STG_M = 2;
  localparam int unsigned STG_W = 3;

  // All-ones Tuse marks an operand the instruction does not read
  localparam logic [T_W_DEF-1:0] T_UNUSED = '1;

  typedef struct packed {
    logic                we;
    logic [RA_W_DEF-1:0] addr;
    logic [T_W_DEF-1:0]  tnew;
  } sb_entry_t;

endpackage

// File: rtl/hazard_operand_check.sv
// Per-operand hazard resolution against the in-flight writer scoreboard:
// the nearest matching writer decides both the stall and the forward source.
module hazard_operand_check
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned FS_W   = 2,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned T_W    = 2
) (
  input  sb_entry_t [STAGES:1] sb,
  input  logic [RA_W-1:0]      addr,
  input  logic [T_W-1:0]       tuse,
  output logic                 stall_c,
  output logic [FS_W-1:0]      fwd_sel_c
);

  logic used;

  // $0 never hazards and an unused operand never looks at the scoreboard
  assign used = (tuse != T_UNUSED) && (addr != '0);

  // Walk oldest to youngest so the nearest match overwrites older ones
  always_comb begin
    stall_c   = 1'b0;
    fwd_sel_c = '0;
    for (int k = int'(STAGES); k >= 1; k--) begin
      if (used && sb[k].we && (sb[k].addr == addr)) begin
        stall_c   = (sb[k].tnew > tuse);
        fwd_sel_c = (sb[k].tnew == '0) ? FS_W'(k) : '0;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: in-flight writer scoreboard, D-stage stall and
// forward selects, plus the mult/div busy countdown.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES  = STG_W,
  parameter int unsigned RA_W    = RA_W_DEF,
  parameter int unsigned T_W     = T_W_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RA_W-1:0]              d_rs_addr,
  input  logic [RA_W-1:0]              d_rt_addr,
  input  logic [T_W-1:0]               d_rs_tuse,
  input  logic [T_W-1:0]               d_rt_tuse,
  input  logic                         d_we,
  input  logic [RA_W-1:0]              d_wr_addr,
  input  logic [T_W-1:0]               d_tnew,
  input  logic                         d_md,
  input  logic                         e_md_start,
  input  logic                         e_md_div,
  output logic                         stall,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel,
  output logic                         md_busy
);

  localparam int unsigned FS_W  = $clog2(STAGES + 1);
  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  sb_entry_t [STAGES:1] sb_q, sb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rs_stall, rt_stall, md_stall;

  // Entry 1 takes the D instruction (or a bubble), older entries age by one stage
  always_comb begin
    sb_d = '0;
    if (!stall) begin
      sb_d[STG_E].we   = d_we;
      sb_d[STG_E].addr = d_wr_addr;
      sb_d[STG_E].tnew = d_tnew;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      sb_d[k+1] = sb_q[k];
      if (sb_q[k].tnew != '0) begin
        sb_d[k+1].tnew = sb_q[k].tnew - T_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (e_md_start) begin
      cnt_d = e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  hazard_operand_check #(
    .STAGES (STAGES),
    .FS_W   (FS_W),
    .RA_W   (RA_W),
    .T_W    (T_W)
  ) u_rs_check (
    .sb        (sb_q),
    .addr      (d_rs_addr),
    .tuse      (d_rs_tuse),
    .stall_c   (rs_stall),
    .fwd_sel_c (fwd_rs_sel)
  );

  hazard_operand_check #(
    .STAGES (STAGES),
    .FS_W   (FS_W),
    .RA_W   (RA_W),
    .T_W    (T_W)
  ) u_rt_check (
    .sb        (sb_q),
    .addr      (d_rt_addr),
    .tuse      (d_rt_tuse),
    .stall_c   (rt_stall),
    .fwd_sel_c (fwd_rt_sel)
  );

  // A start in E already blocks a HI/LO reader in D, before busy rises
  assign md_busy  = (cnt_q != '0);
  assign md_stall = d_md && (md_busy || e_md_start);
  assign stall    = rs_stall | rt_stall | md_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle expectations are queued by the
// driver and checked by a monitor against the DUT outputs.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs_addr, d_rt_addr, d_wr_addr;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_we, d_md, e_md_start, e_md_div;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs_addr  (d_rs_addr),
    .d_rt_addr  (d_rt_addr),
    .d_rs_tuse  (d_rs_tuse),
    .d_rt_tuse  (d_rt_tuse),
    .d_we       (d_we),
    .d_wr_addr  (d_wr_addr),
    .d_tnew     (d_tnew),
    .d_md       (d_md),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Staged stimulus, applied to the DUT at the falling edge
  logic [4:0] n_rs, n_rt, n_wr;
  logic [1:0] n_rs_tuse, n_rt_tuse, n_tnew;
  logic       n_we, n_md, n_start, n_div, n_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    n_rs = 5'd0; n_rt = 5'd0; n_rs_tuse = 2'd3; n_rt_tuse = 2'd3;
    n_we = 1'b0; n_wr = 5'd0; n_tnew = 2'd0;
    n_md = 1'b0; n_start = 1'b0; n_div = 1'b0;
  endtask

  task automatic rd(input logic [4:0] rs, input logic [1:0] rs_t,
                    input logic [4:0] rt, input logic [1:0] rt_t);
    n_rs = rs; n_rs_tuse = rs_t; n_rt = rt; n_rt_tuse = rt_t;
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] t);
    n_we = 1'b1; n_wr = a; n_tnew = t;
  endtask

  task automatic apply();
    reset = n_reset;
    d_rs_addr = n_rs; d_rt_addr = n_rt; d_rs_tuse = n_rs_tuse; d_rt_tuse = n_rt_tuse;
    d_we = n_we; d_wr_addr = n_wr; d_tnew = n_tnew;
    d_md = n_md; e_md_start = n_start; e_md_div = n_div;
  endtask

  // Drive one D-stage cycle and queue what the outputs must show during it
  task automatic cyc(input string tag, input logic es, input logic [1:0] frs,
                     input logic [1:0] frt, input logic eb);
    exp_t e;
    @(negedge clk);
    apply();
    if (n_start) check({tag, ".md_proto"}, 32'(md_busy), 32'd0);
    e.stall = es; e.frs = frs; e.frt = frt; e.busy = eb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    #2;
    while (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".stall"},   32'(stall),      32'(e.stall));
      check({t, ".fwd_rs"},  32'(fwd_rs_sel), 32'(e.frs));
      check({t, ".fwd_rt"},  32'(fwd_rt_sel), 32'(e.frt));
      check({t, ".md_busy"}, 32'(md_busy),    32'(e.busy));
    end
  end

  initial begin
    idle();
    n_reset = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    cyc("rst", 1'b0, 2'd0, 2'd0, 1'b0);
    n_reset = 1'b0;

    // lw $1 (tnew 2) then add $2,$1,$3: one stall cycle, no forward while stalled
    idle(); rd(5'd29, 2'd1, 5'd0, 2'd3); wr(5'd1, 2'd2); cyc("lw1", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd1, 2'd1, 5'd3, 2'd1); wr(5'd2, 2'd1); cyc("add_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("add_go", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd1, 2'd0, 5'd2, 2'd1); cyc("fwd_w", 1'b0, 2'(STG_W), 2'd0, 1'b0);
    idle(); rd(5'd2, 2'd0, 5'd2, 2'd0); cyc("fwd_m_same", 1'b0, 2'(STG_M), 2'(STG_M), 1'b0);
    idle(); cyc("idle1", 1'b0, 2'd0, 2'd0, 1'b0);

    // add $1 (tnew 1) then beq $1,$1: one stall then both forwarded from M
    idle(); rd(5'd4, 2'd1, 5'd5, 2'd1); wr(5'd1, 2'd1); cyc("add1", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd1, 2'd0, 5'd1, 2'd0); cyc("beq_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("beq_fwd", 1'b0, 2'(STG_M), 2'(STG_M), 1'b0);
    idle(); cyc("idle2", 1'b0, 2'd0, 2'd0, 1'b0);

    // Writer to $0 never hazards nor forwards
    idle(); rd(5'd4, 2'd1, 5'd0, 2'd3); wr(5'd0, 2'd1); cyc("w0", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd0, 2'd0, 5'd0, 2'd0); cyc("r0_e", 1'b0, 2'd0, 2'd0, 1'b0);
    cyc("r0_m", 1'b0, 2'd0, 2'd0, 1'b0);

    // Nearest writer shadows older ones; unused operand ignored
    idle(); rd(5'd29, 2'd1, 5'd0, 2'd3); wr(5'd5, 2'd2); cyc("lw5", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd6, 2'd1, 5'd0, 2'd3); wr(5'd5, 2'd1); cyc("ori5", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd5, 2'd1, 5'd5, 2'd1); cyc("shadow_e", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd5, 2'd1, 5'd5, 2'd3); cyc("shadow_m", 1'b0, 2'(STG_M), 2'd0, 1'b0);
    idle(); rd(5'd29, 2'd1, 5'd0, 2'd3); wr(5'd5, 2'd2); cyc("lw5b", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd29, 2'd1, 5'd0, 2'd3); wr(5'd5, 2'd0); cyc("lui5", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); rd(5'd5, 2'd0, 5'd0, 2'd3); cyc("shadow_stall", 1'b0, 2'(STG_E), 2'd0, 1'b0);

    // div start with mflo in D: busy 10 cycles, stall 11 cycles
    idle(); n_md = 1'b1; wr(5'd7, 2'd1); n_start = 1'b1; n_div = 1'b1;
    cyc("div_start", 1'b1, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(); n_md = 1'b1; wr(5'd7, 2'd1); cyc("div_busy", 1'b1, 2'd0, 2'd0, 1'b1);
    end
    idle(); n_md = 1'b1; wr(5'd7, 2'd1); cyc("div_done", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); cyc("idle3", 1'b0, 2'd0, 2'd0, 1'b0);

    // mult: 5 busy cycles, only a HI/LO instruction stalls
    idle(); n_start = 1'b1; cyc("mul_start", 1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(); n_md = (i == 4); cyc("mul_busy", (i == 4), 2'd0, 2'd0, 1'b1);
    end
    idle(); n_md = 1'b1; cyc("mul_done", 1'b0, 2'd0, 2'd0, 1'b0);

    // Reset at count 4 of a div clears busy and the scoreboard
    idle(); n_start = 1'b1; n_div = 1'b1; cyc("rdiv_start", 1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(); if (i == 5) wr(5'd9, 2'd2); cyc("rdiv_busy", 1'b0, 2'd0, 2'd0, 1'b1);
    end
    idle(); rd(5'd9, 2'd0, 5'd0, 2'd3); n_reset = 1'b1; cyc("rst_mid", 1'b1, 2'd0, 2'd0, 1'b1);
    n_reset = 1'b0;
    idle(); rd(5'd9, 2'd0, 5'd9, 2'd0); n_md = 1'b1; cyc("post_rst", 1'b0, 2'd0, 2'd0, 1'b0);
    idle(); cyc("idle4", 1'b0, 2'd0, 2'd0, 1'b0);

    @(posedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
